// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// and the sign helpers used to build magnitudes and fix up signed results.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  // Helpers work on a wide word; callers size-cast in and out, so WIDTH may go up to 64.
  localparam int MAX_W = 128;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic is_neg);
    return cond_neg(v, is_neg);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the HI/LO datapath: shift-add multiply step, or (with
// MULDIV_DIV_EN defined) a restoring-divide step selected by i_div.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef MULDIV_DIV_EN
  input  logic               i_div,
`endif
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_acc;

  // Multiply: accumulator is {partial product, remaining multiplier bits}.
  assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
  assign w_mul_acc = {w_sum, i_acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]       w_shift;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_div_acc;

  // Divide: accumulator is {partial remainder, dividend bits shifting into quotient}.
  // When the subtract succeeds the true difference is below the divisor, so WIDTH bits hold it.
  assign w_shift   = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, i_operand});
  assign w_diff    = w_shift[WIDTH-1:0] - i_operand;
  assign w_div_acc = w_ge ? {w_diff, i_acc[WIDTH-2:0], 1'b1}
                          : {w_shift[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};

  assign o_acc = i_div ? w_div_acc : w_mul_acc;
`else
  assign o_acc = w_mul_acc;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO path and start/busy/done
// handshake. Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A_data,
  input  logic [WIDTH-1:0] B_data,
  input  logic             mt_en,
  input  logic             mt_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: start is accepted only in IDLE; busy is high from the accept edge
  // until the FIX edge; done pulses for the single cycle after HI/LO are written.
  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_operand;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_start_ok;
  logic             w_last;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_step_acc;
  logic [PW-1:0]    w_prod;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

`ifdef MULDIV_DIV_EN
  logic             r_div;
  logic             r_div0;
  assign w_start_ok = start && (r_state == IDLE);
`else
  assign w_start_ok = start && (r_state == IDLE) && !op[1];
`endif

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_sign_a = op[0] & A_data[WIDTH-1];
  assign w_sign_b = op[0] & B_data[WIDTH-1];
  assign w_abs_a  = WIDTH'(abs_val(MAX_W'(A_data), w_sign_a));
  assign w_abs_b  = WIDTH'(abs_val(MAX_W'(B_data), w_sign_b));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = RUN;
      RUN:     if (w_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_cnt <= '0;
    else if (r_state == RUN)  r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    else                      r_cnt <= '0;
  end

  // Multiply iterates over |B| adding |A|; divide iterates over |A| against |B|.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_operand <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div     <= 1'b0;
      r_div0    <= 1'b0;
`endif
    end else if (w_start_ok) begin
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
`ifdef MULDIV_DIV_EN
      r_div     <= op[1];
      r_div0    <= op[1] && (B_data == '0);
      r_acc     <= op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
      r_operand <= op[1] ? w_abs_b : w_abs_a;
`else
      r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
      r_operand <= w_abs_a;
`endif
    end else if (r_state == RUN) begin
      r_acc <= w_step_acc;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .i_div     (r_div),
`endif
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_step_acc)
  );

  assign w_prod = PW'(cond_neg(MAX_W'(r_acc), r_sign_a ^ r_sign_b));

  // Divide by zero leaves |A| as the remainder, so HI recovers A_data via the sign fix-up.
  always_comb begin
    w_fix_hi = w_prod[PW-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_div) begin
      w_fix_hi = WIDTH'(cond_neg(MAX_W'(r_acc[PW-1:WIDTH]), r_sign_a));
      w_fix_lo = r_div0 ? '1 : WIDTH'(cond_neg(MAX_W'(r_acc[WIDTH-1:0]), r_sign_a ^ r_sign_b));
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == FIX) begin
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
        r_done <= 1'b1;
      end else if ((r_state == IDLE) && mt_en && !w_start_ok) begin
        if (mt_sel) r_hi <= A_data;
        else        r_lo <= A_data;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative HI/LO multiply/divide unit for the MIPS core, directly downstream of the register file. It consumes the two read ports (rs on `A_data`, rt on `B_data`) for MULT/MULTU/DIV/DIVU and MTHI/MTLO, and holds the HI/LO architectural registers. Control uses a start/busy/done handshake toward the control unit. `hi`/`lo` feed the writeback mux for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. The iteration count equals WIDTH.
- `clk`  in  1  system clock; rising-edge active.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A_data`  in  WIDTH  rs operand (multiplicand/dividend); also the MTHI/MTLO source.
- `B_data`  in  WIDTH  rt operand (multiplier/divisor).
- `mt_en`  in  1  move-to request.
- `mt_sel`  in  1  0 = write LO, 1 = write HI.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: lasts exactly WIDTH cycles, tracked by a counter 0..WIDTH-1; at count WIDTH-1 → FIX.
  - FIX: one cycle, then → IDLE.
- Capture on the start edge:
  - magnitudes of A and B; signed ops only take the magnitude, unsigned ops use raw values
  - sign of A and sign of B
  - `op`
  - divide-by-zero flag (B == 0, div ops)
- Multiply: shift-add, one multiplier bit per RUN cycle, into a 2·WIDTH accumulator. In FIX, MULT negates the 2·WIDTH product when signA ≠ signB. HI = upper half, LO = lower half.
- Divide: restoring, one quotient bit per RUN cycle. In FIX, for DIV:
  - quotient is negated when signA ≠ signB
  - remainder takes the sign of A
  - LO = quotient, HI = remainder.
- Divide by zero: full latency still applies. Result is LO = all ones, HI = original A_data.
- Signed overflow (0x80000000 / -1) falls out naturally as LO = 0x80000000, HI = 0. No special case.
- MTHI/MTLO: when `mt_en` is high and the unit is IDLE, A_data is written to the register selected by `mt_sel` on the next edge.
  - `mt_en` while busy is ignored.
  - `mt_en` together with an accepted `start` is dropped; start wins.
- `start` while busy is ignored. No queueing.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0.
- Edge numbering, with the start edge as E0:
  - E0: operands captured; `busy` rises after E0.
  - E1..E32: RUN iterations.
  - E33: FIX; `hi`, `lo` and `done` update.
  - `busy` falls after E33. It is high for 33 cycles in total.
  - `done` is high for exactly one cycle, E33 to E34.
- A new `start` is accepted at E33+1, i.e. while `done` is high. Back-to-back throughput is one op per 34 cycles.
- `hi`/`lo` stay unchanged during RUN and FIX until E33. MFHI/MFLO during busy therefore return the old values; stalling is the control unit's job.
- Reset mid-operation aborts immediately and asynchronously: all outputs go to reset values and no `done` pulse is produced.

## Configuration
- `MULDIV_DIV_EN` defined: full divide support as specified above.
- `MULDIV_DIV_EN` undefined:
  - the divider datapath is compiled out
  - `start` with op[1] = 1 is ignored: `busy` stays 0, no `done`, HI/LO unchanged
  - multiply timing is unaffected.

## Structure
- Package `muldiv_pkg`:
  - op encodings `OP_MULTU/OP_MULT/OP_DIVU/OP_DIV`
  - FSM state enum `IDLE/RUN/FIX`
  - `WIDTH` default
  - abs and conditional-negate functions.
- One sub-module, `muldiv_step`: combinational single-iteration datapath (add-shift step or restore-subtract step, selected by op[1]).
- The FSM, counter, HI/LO registers and the MT path live in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULT -3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; DIVU 100 / 7 → LO = 14, HI = 2.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5 after full latency. With `MULDIV_DIV_EN` undefined, the same start gives no `busy`, no `done`, HI/LO unchanged.
- MTLO with A = 0x1234 while idle → `lo` = 0x1234 next cycle. MTHI and a second `start` issued during busy → both ignored, first result intact.
- `rst` pulled low at RUN cycle 10 → `busy`, `hi`, `lo` = 0 immediately; no `done`; a fresh MULTU 6 × 7 afterwards → LO = 42.
